algo_2rw_bank_arb: RTL and testbench
====================================

Name: algo_2rw_bank_arb

Overview:
- Front-end scheduler for the 2RW, 4-bank (NUMRWPT*NUMRWPT) physical memory array.
- Accepts read/write commands on two logical RW ports and maps each address to a physical bank: bank = addr[BITPBNK-1:0], row = addr[BITADDR-1:BITPBNK].
- Resolves same-bank conflicts with a one-deep per-port hold register and round-robin priority.
- Zero-initialises all banks after reset, and returns read data with a fixed, pipelined latency.

Parameters:
- WIDTH, 64, data width per port (no ECC/parity in this block).
- BITADDR, 11, logical address width.
- NUMPBNK, 4, number of physical banks.
- BITPBNK, 2, bank select width.
- NUMSROW, 512, rows per physical bank (2**(BITADDR-BITPBNK)).
- BITSROW, 9, row address width.
- SRAM_DELAY, 1, bank read latency in cycles, from t1_readB to t1_doutB.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- ready  out  1  high once initialisation is complete.
- rw_read  in  2  per-port read request.
- rw_write  in  2  per-port write request.
- rw_addr  in  2*BITADDR  per-port address.
- rw_din  in  2*WIDTH  per-port write data.
- rw_rdy  out  2  per-port accept; a request is taken when (read|write) & rw_rdy.
- rw_vld  out  2  per-port read data valid.
- rw_dout  out  2*WIDTH  per-port read data.
- t1_writeA  out  NUMPBNK  bank write enable.
- t1_addrA  out  NUMPBNK*BITSROW  bank write row.
- t1_dinA  out  NUMPBNK*WIDTH  bank write data.
- t1_bwA  out  NUMPBNK*WIDTH  bank bit-write mask.
- t1_readB  out  NUMPBNK  bank read enable.
- t1_addrB  out  NUMPBNK*BITSROW  bank read row.
- t1_doutB  in  NUMPBNK*WIDTH  bank read data.

Behaviour:
- Reset (rst=0, async): ready=0, rw_rdy=0, rw_vld=0, rw_dout=0, all t1_* outputs=0.
  - Hold registers, read pipes and priority (prio=0) are cleared; FSM goes to INIT, row counter = 0.
  - Reset mid-operation drops in-flight reads (no rw_vld) and restarts INIT.
- FSM INIT: each cycle writes 0 to row cnt of all four banks (t1_writeA=4'hF, t1_bwA all ones).
  - cnt increments each cycle; at cnt==NUMSROW-1 the FSM moves to RUN.
  - INIT lasts exactly NUMSROW cycles; rw_rdy=0 throughout and requests are ignored.
- FSM RUN: ready=1. RUN is left only by reset.
- rw_rdy[i] = ready & ~hold_vld[i].
- A request with both read and write set is treated as a write.
- Arbitration each cycle in RUN; candidate for port i = hold_i if valid, else the newly accepted request.
  - Conflict = both candidates are reads to the same bank, or both are writes to the same bank.
  - A read and a write to the same bank issue together: write on port A, read on port B. There is no bypass; the read returns the value stored before the write.
  - On conflict, a held candidate beats a new one. Two new candidates: the winner is port prio, and prio toggles.
  - The loser is captured into its hold register and issues the next cycle.
  - Hold registers never both hold, so there is no starvation.
- t1_* outputs are registered.
  - Issue appears one cycle after arbitration.
  - t1_bwA is all ones for a written bank and 0 otherwise.
  - Idle banks drive enable=0 with address and data held.
- Read return: per-port delay line of {valid, bank} of depth SRAM_DELAY+1 behind issue; rw_dout is a registered mux of t1_doutB.
  - Latency from acceptance to rw_vld: SRAM_DELAY+2 uncontended, SRAM_DELAY+3 if held.
  - rw_vld is a one-cycle pulse per read; read returns per port stay in order.
- Writes produce no response.

Decomposition:
- Package algo_2rw_arb_pkg: bank/row split functions; FSM enum {INIT, RUN}; request struct {rd, wr, bank, row, data}.
- Sub-module algo_2rw_rd_pipe: parameterised {valid, bank} shift line with async-low clear, instantiated once per port.

Test Plan:
- Reset release -> ready rises exactly 512 cycles later; every bank/row is written with 0 and t1_bwA=all ones.
- Port0 write addr 0x004 data 0xA5, then port1 read 0x004 -> rw_vld[1] 3 cycles after accept (SRAM_DELAY=1), rw_dout = 0xA5.
- Both ports read bank 1 (0x005, 0x009) in the same cycle with prio=0:
  - port0 issues first; port1 is held and rw_rdy[1]=0 for 1 cycle;
  - rw_vld[1] one cycle after rw_vld[0]; prio becomes 1.
- Both ports write bank 2 in the same cycle, then repeat -> the second conflict is won by port1, confirming alternation.
- Port0 writes 0x003 and port1 reads 0x003 in the same cycle -> both issue in the same cycle and the read returns the pre-write value.
- Assert rst mid-read (after issue, before rw_vld) -> no rw_vld, ready=0, INIT restarts from row 0.

Source files
------------

// File: rtl/algo_2rw_arb_pkg.sv
// Shared types and address helpers for the 2RW, 4-bank front-end arbiter.
package algo_2rw_arb_pkg;

    localparam int unsigned ArbWidth   = 64;
    localparam int unsigned ArbBitAddr = 11;
    localparam int unsigned ArbBitPbnk = 2;
    localparam int unsigned ArbBitSrow = ArbBitAddr - ArbBitPbnk;

    typedef enum logic {INIT, RUN} arb_state_e;

    typedef struct packed {
        logic [ArbBitSrow-1:0] row;
        logic [ArbBitPbnk-1:0] bank;
    } arb_loc_t;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic [ArbBitPbnk-1:0] bank;
        logic [ArbBitSrow-1:0] row;
        logic [ArbWidth-1:0]   data;
    } arb_req_t;

    // Low address bits select the bank so sequential addresses spread across banks.
    function automatic arb_loc_t split_addr(input logic [ArbBitAddr-1:0] addr);
        arb_loc_t loc;
        loc.bank = addr[ArbBitPbnk-1:0];
        loc.row  = addr[ArbBitAddr-1:ArbBitPbnk];
        return loc;
    endfunction

endpackage

// File: rtl/algo_2rw_rd_pipe.sv
// Delay line carrying {valid, bank} of an issued read until its bank data is available.
module algo_2rw_rd_pipe #(
    parameter int unsigned Depth = 2,
    parameter int unsigned BankW = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vld_i,
    input  logic [BankW-1:0] bank_i,
    output logic             vld_o,
    output logic [BankW-1:0] bank_o
);

    logic [Depth-1:0]            vld_q;
    logic [Depth-1:0][BankW-1:0] bank_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= '0;
            bank_q <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            bank_q[0] <= bank_i;
            for (int k = 1; k < Depth; k++) begin
                vld_q[k]  <= vld_q[k-1];
                bank_q[k] <= bank_q[k-1];
            end
        end
    end

    assign vld_o  = vld_q[Depth-1];
    assign bank_o = bank_q[Depth-1];

endmodule

// File: rtl/algo_2rw_bank_arb.sv
// Two-port RW scheduler for a 4-bank array: same-bank arbitration with a one-deep hold
// per port, zero fill of every bank after reset, and fixed-latency read return.
module algo_2rw_bank_arb
    import algo_2rw_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = ArbWidth,
    parameter int unsigned BITADDR    = ArbBitAddr,
    parameter int unsigned NUMPBNK    = 4,
    parameter int unsigned BITPBNK    = ArbBitPbnk,
    parameter int unsigned NUMSROW    = 512,
    parameter int unsigned BITSROW    = ArbBitSrow,
    parameter int unsigned SRAM_DELAY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       ready,
    input  logic [1:0]                 rw_read,
    input  logic [1:0]                 rw_write,
    input  logic [2*BITADDR-1:0]       rw_addr,
    input  logic [2*WIDTH-1:0]         rw_din,
    output logic [1:0]                 rw_rdy,
    output logic [1:0]                 rw_vld,
    output logic [2*WIDTH-1:0]         rw_dout,
    output logic [NUMPBNK-1:0]         t1_writeA,
    output logic [NUMPBNK*BITSROW-1:0] t1_addrA,
    output logic [NUMPBNK*WIDTH-1:0]   t1_dinA,
    output logic [NUMPBNK*WIDTH-1:0]   t1_bwA,
    output logic [NUMPBNK-1:0]         t1_readB,
    output logic [NUMPBNK*BITSROW-1:0] t1_addrB,
    input  logic [NUMPBNK*WIDTH-1:0]   t1_doutB
);

    localparam int unsigned PipeDepth = SRAM_DELAY + 1;

    arb_state_e         state_q, state_d;
    logic [BITSROW-1:0] cnt_q, cnt_d;
    logic               prio_q, prio_d;
    logic [1:0]         hold_vld_q, hold_vld_d;
    arb_req_t           hold_q [2];
    arb_req_t           hold_d [2];
    arb_req_t           new_req [2];
    arb_req_t           cand [2];
    arb_loc_t           loc [2];
    logic [1:0]         cand_vld, lose, issue, issue_rd;
    logic [1:0][BITPBNK-1:0] issue_bank;
    logic               conflict, win;

    logic [NUMPBNK-1:0]              wa_q, wa_d, rb_q, rb_d;
    logic [NUMPBNK-1:0][BITSROW-1:0] addra_q, addra_d, addrb_q, addrb_d;
    logic [NUMPBNK-1:0][WIDTH-1:0]   dina_q, dina_d, bwa_q, bwa_d;
    logic [NUMPBNK-1:0][WIDTH-1:0]   doutb;

    logic [1:0]              pipe_vld, vld_q;
    logic [1:0][BITPBNK-1:0] pipe_bank;
    logic [1:0][WIDTH-1:0]   dout_q;

    assign ready  = (state_q == RUN);
    assign rw_rdy = {2{ready}} & ~hold_vld_q;
    assign doutb  = t1_doutB;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + BITSROW'(1);
            if (cnt_q == BITSROW'(NUMSROW - 1)) begin
                state_d = RUN;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            loc[i]          = split_addr(rw_addr[i*BITADDR +: BITADDR]);
            new_req[i].rd   = rw_read[i] & ~rw_write[i];
            new_req[i].wr   = rw_write[i];
            new_req[i].bank = loc[i].bank;
            new_req[i].row  = loc[i].row;
            new_req[i].data = rw_din[i*WIDTH +: WIDTH];
            cand[i]         = hold_vld_q[i] ? hold_q[i] : new_req[i];
            cand_vld[i]     = hold_vld_q[i] | ((rw_read[i] | rw_write[i]) & rw_rdy[i]);
        end
        // A read and a write to one bank can share it: the write uses port A, the read port B.
        conflict = (&cand_vld) && (cand[0].bank == cand[1].bank) &&
                   ((cand[0].rd && cand[1].rd) || (cand[0].wr && cand[1].wr));
        win      = hold_vld_q[0] ? 1'b0 : (hold_vld_q[1] ? 1'b1 : prio_q);
        prio_d   = prio_q ^ (conflict & ~(|hold_vld_q));
        lose     = 2'b00;
        if (conflict) begin
            lose = win ? 2'b01 : 2'b10;
        end
        for (int i = 0; i < 2; i++) begin
            issue[i]      = cand_vld[i] & ~lose[i];
            issue_rd[i]   = issue[i] & cand[i].rd;
            issue_bank[i] = cand[i].bank;
            hold_vld_d[i] = lose[i];
            hold_d[i]     = lose[i] ? cand[i] : hold_q[i];
        end
    end

    always_comb begin
        wa_d    = '0;
        rb_d    = '0;
        bwa_d   = '0;
        addra_d = addra_q;
        dina_d  = dina_q;
        addrb_d = addrb_q;
        if (state_q == INIT) begin
            wa_d   = '1;
            bwa_d  = '1;
            dina_d = '0;
            for (int b = 0; b < NUMPBNK; b++) begin
                addra_d[b] = cnt_q;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (issue[i]) begin
                    if (cand[i].wr) begin
                        wa_d[cand[i].bank]    = 1'b1;
                        bwa_d[cand[i].bank]   = '1;
                        addra_d[cand[i].bank] = cand[i].row;
                        dina_d[cand[i].bank]  = cand[i].data;
                    end else begin
                        rb_d[cand[i].bank]    = 1'b1;
                        addrb_d[cand[i].bank] = cand[i].row;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            prio_q     <= 1'b0;
            hold_vld_q <= '0;
            for (int i = 0; i < 2; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio_q     <= prio_d;
            hold_vld_q <= hold_vld_d;
            for (int i = 0; i < 2; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wa_q    <= '0;
            rb_q    <= '0;
            bwa_q   <= '0;
            addra_q <= '0;
            dina_q  <= '0;
            addrb_q <= '0;
        end else begin
            wa_q    <= wa_d;
            rb_q    <= rb_d;
            bwa_q   <= bwa_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            addrb_q <= addrb_d;
        end
    end

    assign t1_writeA = wa_q;
    assign t1_addrA  = addra_q;
    assign t1_dinA   = dina_q;
    assign t1_bwA    = bwa_q;
    assign t1_readB  = rb_q;
    assign t1_addrB  = addrb_q;

    for (genvar g = 0; g < 2; g++) begin : g_rd_pipe
        algo_2rw_rd_pipe #(
            .Depth (PipeDepth),
            .BankW (BITPBNK)
        ) u_rd_pipe (
            .clk_i  (clk),
            .rst_ni (rst),
            .vld_i  (issue_rd[g]),
            .bank_i (issue_bank[g]),
            .vld_o  (pipe_vld[g]),
            .bank_o (pipe_bank[g])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= '0;
            dout_q <= '0;
        end else begin
            vld_q <= pipe_vld;
            for (int i = 0; i < 2; i++) begin
                if (pipe_vld[i]) begin
                    dout_q[i] <= doutb[pipe_bank[i]];
                end
            end
        end
    end

    assign rw_vld  = vld_q;
    assign rw_dout = dout_q;

endmodule

// File: tb/tb_algo_2rw_bank_arb.sv
// Directed bench for algo_2rw_bank_arb with a behavioural 4-bank 1R1W memory model.
module tb_algo_2rw_bank_arb;

    localparam int W  = 64;
    localparam int NB = 4;
    localparam int RW = 9;
    localparam int NR = 512;

    logic            clk;
    logic            rst;
    logic            ready;
    logic [1:0]      rw_read, rw_write, rw_rdy, rw_vld;
    logic [21:0]     rw_addr;
    logic [2*W-1:0]  rw_din, rw_dout;
    logic [NB-1:0]   t1_writeA, t1_readB;
    logic [NB*RW-1:0] t1_addrA, t1_addrB;
    logic [NB*W-1:0] t1_dinA, t1_bwA, t1_doutB;

    logic [W-1:0] mem [NB][NR];

    int checks;
    int errors;

    localparam logic [NB*W-1:0] Bw0 = {192'h0, {64{1'b1}}};
    localparam logic [NB*W-1:0] Bw2 = {64'h0, {64{1'b1}}, 128'h0};

    algo_2rw_bank_arb dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .rw_read   (rw_read),
        .rw_write  (rw_write),
        .rw_addr   (rw_addr),
        .rw_din    (rw_din),
        .rw_rdy    (rw_rdy),
        .rw_vld    (rw_vld),
        .rw_dout   (rw_dout),
        .t1_writeA (t1_writeA),
        .t1_addrA  (t1_addrA),
        .t1_dinA   (t1_dinA),
        .t1_bwA    (t1_bwA),
        .t1_readB  (t1_readB),
        .t1_addrB  (t1_addrB),
        .t1_doutB  (t1_doutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle read latency bank model; a same-edge read sees the old contents.
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (t1_readB[b]) t1_doutB[b*W +: W] <= mem[b][t1_addrB[b*RW +: RW]];
            if (t1_writeA[b]) begin
                mem[b][t1_addrA[b*RW +: RW]] <=
                    (mem[b][t1_addrA[b*RW +: RW]] & ~t1_bwA[b*W +: W]) |
                    (t1_dinA[b*W +: W] & t1_bwA[b*W +: W]);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr, input logic [10:0] a0,
                         input logic [10:0] a1, input logic [63:0] d0, input logic [63:0] d1);
        rw_read  = rd;
        rw_write = wr;
        rw_addr  = {a1, a0};
        rw_din   = {d1, d0};
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 11'h0, 11'h0, 64'h0, 64'h0);
    endtask

    // Walks the zero-fill phase after reset release; callers judge the results.
    task automatic run_init(output int rdy_cycle, output int bad_cycle, output int rdy_bad);
        rdy_cycle = 0;
        bad_cycle = 0;
        rdy_bad   = 0;
        for (int k = 1; k <= 600; k++) begin
            cyc();
            if (t1_writeA !== 4'hF || t1_bwA !== {NB*W{1'b1}} || t1_dinA !== '0 ||
                t1_addrA !== {4{9'(k - 1)}}) begin
                if (bad_cycle == 0) bad_cycle = k;
            end
            if (ready === 1'b1) begin
                rdy_cycle = k;
                break;
            end
            if (rw_rdy !== 2'b00) rdy_bad = k;
        end
        idle();
    endtask

    task automatic test_reset();
        int rdy_cycle, bad_cycle, rdy_bad;
        rst = 1'b0;
        idle();
        repeat (3) cyc();
        checks++;
        if ({ready, rw_rdy, rw_vld} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000", {ready, rw_rdy, rw_vld});
        end
        checks++;
        if ({t1_writeA, t1_readB, t1_addrA, t1_addrB, t1_dinA, t1_bwA, rw_dout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: t1/rw_dout not zero (writeA=%b readB=%b)",
                     t1_writeA, t1_readB);
        end
        // A write held on port 0 through INIT must be ignored.
        drive(2'b00, 2'b01, 11'h000, 11'h0, 64'hFF, 64'h0);
        rst = 1'b1;
        run_init(rdy_cycle, bad_cycle, rdy_bad);
        checks++;
        if (rdy_cycle != 512) begin
            errors++;
            $display("FAIL init_ready: ready rose at cycle %0d want 512", rdy_cycle);
        end
        checks++;
        if (bad_cycle != 0) begin
            errors++;
            $display("FAIL init_rows: first bad cycle %0d got 0 want clean zero fill", bad_cycle);
        end
        checks++;
        if (rdy_bad != 0) begin
            errors++;
            $display("FAIL init_rdy: rw_rdy high at cycle %0d want 00", rdy_bad);
        end
        cyc();
        checks++;
        if ({t1_writeA, t1_readB, rw_rdy} !== 10'b0000_0000_11) begin
            errors++;
            $display("FAIL run_idle: got wA=%b rB=%b rdy=%b want 0000 0000 11",
                     t1_writeA, t1_readB, rw_rdy);
        end
    endtask

    task automatic test_write_read();
        int lat;
        drive(2'b00, 2'b01, 11'h004, 11'h0, 64'hA5, 64'h0);
        cyc();
        checks++;
        if (t1_writeA !== 4'b0001 || t1_addrA[8:0] !== 9'd1 || t1_dinA[63:0] !== 64'hA5 ||
            t1_bwA !== Bw0) begin
            errors++;
            $display("FAIL wr_issue: wA=%b row=%0d din=%h want 0001 1 a5",
                     t1_writeA, t1_addrA[8:0], t1_dinA[63:0]);
        end
        drive(2'b10, 2'b00, 11'h0, 11'h004, 64'h0, 64'h0);
        cyc();
        idle();
        checks++;
        if (t1_readB !== 4'b0001 || t1_addrB[8:0] !== 9'd1) begin
            errors++;
            $display("FAIL rd_issue: rB=%b row=%0d want 0001 1", t1_readB, t1_addrB[8:0]);
        end
        lat = 0;
        for (int j = 2; j <= 8; j++) begin
            cyc();
            if (rw_vld[1] === 1'b1) begin
                lat = j;
                break;
            end
        end
        checks++;
        if (lat != 3 || rw_dout[127:64] !== 64'hA5) begin
            errors++;
            $display("FAIL rd_latency: lat=%0d dout=%h want 3 a5", lat, rw_dout[127:64]);
        end
        cyc();
        checks++;
        if (rw_vld !== 2'b00) begin
            errors++;
            $display("FAIL rd_pulse: rw_vld=%b want 00", rw_vld);
        end
    endtask

    task automatic test_write_conflict(input logic [63:0] d0, input logic [63:0] d1,
                                       input logic exp_win);
        logic [63:0] first_d, second_d;
        logic [8:0]  first_r, second_r;
        first_d  = exp_win ? d1 : d0;
        second_d = exp_win ? d0 : d1;
        first_r  = exp_win ? 9'd2 : 9'd1;
        second_r = exp_win ? 9'd1 : 9'd2;
        drive(2'b00, 2'b11, 11'h006, 11'h00A, d0, d1);
        cyc();
        idle();
        checks++;
        if (t1_writeA !== 4'b0100 || t1_dinA[191:128] !== first_d ||
            t1_addrA[26:18] !== first_r || t1_bwA !== Bw2 ||
            rw_rdy !== (exp_win ? 2'b10 : 2'b01)) begin
            errors++;
            $display("FAIL wconf_first: wA=%b din=%h row=%0d rdy=%b want 0100 %h %0d win=%0d",
                     t1_writeA, t1_dinA[191:128], t1_addrA[26:18], rw_rdy,
                     first_d, first_r, exp_win);
        end
        cyc();
        checks++;
        if (t1_writeA !== 4'b0100 || t1_dinA[191:128] !== second_d ||
            t1_addrA[26:18] !== second_r || rw_rdy !== 2'b11) begin
            errors++;
            $display("FAIL wconf_second: wA=%b din=%h row=%0d rdy=%b want 0100 %h %0d 11",
                     t1_writeA, t1_dinA[191:128], t1_addrA[26:18], rw_rdy, second_d, second_r);
        end
        cyc();
    endtask

    task automatic test_read_conflict();
        drive(2'b00, 2'b01, 11'h005, 11'h0, 64'h55, 64'h0);
        cyc();
        drive(2'b00, 2'b01, 11'h009, 11'h0, 64'h99, 64'h0);
        cyc();
        drive(2'b00, 2'b01, 11'h00D, 11'h0, 64'hDD, 64'h0);
        cyc();
        idle();
        cyc();
        drive(2'b11, 2'b00, 11'h005, 11'h009, 64'h0, 64'h0);
        cyc();
        // Port 0 won; a new port-0 read now meets the held port-1 read.
        drive(2'b01, 2'b00, 11'h00D, 11'h0, 64'h0, 64'h0);
        checks++;
        if (t1_readB !== 4'b0010 || t1_addrB[17:9] !== 9'd1 || rw_rdy !== 2'b01) begin
            errors++;
            $display("FAIL rconf_first: rB=%b row=%0d rdy=%b want 0010 1 01",
                     t1_readB, t1_addrB[17:9], rw_rdy);
        end
        cyc();
        idle();
        checks++;
        if (t1_readB !== 4'b0010 || t1_addrB[17:9] !== 9'd2 || rw_rdy !== 2'b10) begin
            errors++;
            $display("FAIL rconf_held_wins: rB=%b row=%0d rdy=%b want 0010 2 10",
                     t1_readB, t1_addrB[17:9], rw_rdy);
        end
        cyc();
        checks++;
        if (t1_addrB[17:9] !== 9'd3 || rw_vld !== 2'b01 || rw_dout[63:0] !== 64'h55) begin
            errors++;
            $display("FAIL rconf_vld0: row=%0d vld=%b dout0=%h want 3 01 55",
                     t1_addrB[17:9], rw_vld, rw_dout[63:0]);
        end
        cyc();
        checks++;
        if (rw_vld !== 2'b10 || rw_dout[127:64] !== 64'h99) begin
            errors++;
            $display("FAIL rconf_vld1: vld=%b dout1=%h want 10 99", rw_vld, rw_dout[127:64]);
        end
        cyc();
        checks++;
        if (rw_vld !== 2'b01 || rw_dout[63:0] !== 64'hDD) begin
            errors++;
            $display("FAIL rconf_vld0b: vld=%b dout0=%h want 01 dd", rw_vld, rw_dout[63:0]);
        end
        cyc();
    endtask

    task automatic test_rw_same_bank();
        drive(2'b10, 2'b01, 11'h003, 11'h003, 64'h77, 64'h0);
        cyc();
        idle();
        checks++;
        if (t1_writeA !== 4'b1000 || t1_readB !== 4'b1000 || rw_rdy !== 2'b11) begin
            errors++;
            $display("FAIL rw_same_issue: wA=%b rB=%b rdy=%b want 1000 1000 11",
                     t1_writeA, t1_readB, rw_rdy);
        end
        cyc();
        cyc();
        checks++;
        if (rw_vld !== 2'b10 || rw_dout[127:64] !== 64'h0) begin
            errors++;
            $display("FAIL rw_same_old: vld=%b dout1=%h want 10 0", rw_vld, rw_dout[127:64]);
        end
        drive(2'b10, 2'b00, 11'h0, 11'h003, 64'h0, 64'h0);
        cyc();
        idle();
        cyc();
        cyc();
        checks++;
        if (rw_vld !== 2'b10 || rw_dout[127:64] !== 64'h77) begin
            errors++;
            $display("FAIL rw_same_new: vld=%b dout1=%h want 10 77", rw_vld, rw_dout[127:64]);
        end
        cyc();
    endtask

    task automatic test_reset_mid_read();
        int rdy_cycle, bad_cycle, rdy_bad, seen;
        drive(2'b01, 2'b00, 11'h003, 11'h0, 64'h0, 64'h0);
        cyc();
        idle();
        checks++;
        if (t1_readB !== 4'b1000) begin
            errors++;
            $display("FAIL mid_issue: rB=%b want 1000", t1_readB);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({ready, rw_rdy, rw_vld, t1_readB} !== 9'b0) begin
            errors++;
            $display("FAIL mid_reset: ready=%b rdy=%b vld=%b rB=%b want all 0",
                     ready, rw_rdy, rw_vld, t1_readB);
        end
        seen = 0;
        repeat (4) begin
            cyc();
            if (rw_vld !== 2'b00) seen++;
        end
        rst = 1'b1;
        run_init(rdy_cycle, bad_cycle, rdy_bad);
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL mid_no_vld: rw_vld seen %0d times want 0", seen);
        end
        checks++;
        if (rdy_cycle != 512 || bad_cycle != 0) begin
            errors++;
            $display("FAIL mid_reinit: ready at %0d first bad row cycle %0d want 512 0",
                     rdy_cycle, bad_cycle);
        end
        drive(2'b10, 2'b00, 11'h0, 11'h003, 64'h0, 64'h0);
        cyc();
        idle();
        cyc();
        cyc();
        checks++;
        if (rw_vld !== 2'b10 || rw_dout[127:64] !== 64'h0) begin
            errors++;
            $display("FAIL mid_rezero: vld=%b dout1=%h want 10 0", rw_vld, rw_dout[127:64]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_write_conflict(64'h111, 64'h222, 1'b0);
        test_write_conflict(64'h333, 64'h444, 1'b1);
        test_read_conflict();
        test_write_conflict(64'h555, 64'h666, 1'b1);
        test_rw_same_bank();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
